// File: rtl/skinny_sbox_layer_sched_d1_if.sv
// rtl/skinny_sbox_layer_sched_d1_if.sv - port bundle between the layer scheduler and the shared masked S-box
// The master side drives S-box inputs, fresh randomness and clock enable; the slave side returns output shares.
interface skinny_sbox_layer_sched_d1_if #(
  parameter int FRESH_W = 8
);
  logic [3:0]         sbox_x_s0;
  logic [3:0]         sbox_x_s1;
  logic [FRESH_W-1:0] sbox_fresh;
  logic               sbox_en;
  logic [3:0]         sbox_y_s0;
  logic [3:0]         sbox_y_s1;

  modport master (
    output sbox_x_s0, sbox_x_s1, sbox_fresh, sbox_en,
    input  sbox_y_s0, sbox_y_s1
  );

  modport slave (
    input  sbox_x_s0, sbox_x_s1, sbox_fresh, sbox_en,
    output sbox_y_s0, sbox_y_s1
  );
endinterface

// File: rtl/skinny_sbox_layer_sched_d1.sv
// rtl/skinny_sbox_layer_sched_d1.sv - issues a 16-nibble masked state through one shared HPC3 S-box and reassembles it
// Optional S-box clock gating on randomness starvation: define SKINNY_SCHED_CLK_GATE_EN.
module skinny_sbox_layer_sched_d1 #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 2,
  parameter int FRESH_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   state_in_s0,
  input  logic [4*NIBBLES-1:0]   state_in_s1,
  input  logic [FRESH_W-1:0]     fresh_in,
  input  logic                   fresh_valid,
  output logic                   fresh_ready,
  skinny_sbox_layer_sched_d1_if.master sbox,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   state_out_s0,
  output logic [4*NIBBLES-1:0]   state_out_s1,
  output logic                   rnd_err
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int TW = (SBOX_LAT > 1) ? SBOX_LAT - 1 : 1;
  localparam int SW = 4 * NIBBLES;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   in_s0_q, in_s0_d, in_s1_q, in_s1_d;
  logic [SW-1:0]   out_s0_q, out_s0_d, out_s1_q, out_s1_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [IW-1:0]   tag_idx_q [TW];
  logic [IW-1:0]   tag_idx_d [TW];
  logic            rnd_err_q, rnd_err_d;
  logic            alive_q, alive_d;

  logic            issue, any_tag, advance, wr_en;
  logic [IW-1:0]   wr_idx;
  logic [3:0]      x_s0, x_s1;

  // tag[0] is the issue strobe itself; only stages 1..SBOX_LAT-1 are registered
  always_comb begin
    any_tag = (SBOX_LAT > 1) && (|tag_q);
    issue   = (state_q == S_RUN) && fresh_valid;
`ifdef SKINNY_SCHED_CLK_GATE_EN
    advance = alive_q && !(any_tag && !fresh_valid);
`else
    advance = alive_q;
`endif
    wr_en   = (SBOX_LAT > 1) ? tag_q[TW-1] : issue;
    wr_idx  = (SBOX_LAT > 1) ? tag_idx_q[TW-1] : idx_q;
  end

  // Each share has its own select path so the two shares never meet in logic
  always_comb begin
    x_s0 = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (issue && (idx_q == IW'(i))) x_s0 = in_s0_q[4*i +: 4];
    end
  end

  always_comb begin
    x_s1 = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (issue && (idx_q == IW'(i))) x_s1 = in_s1_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_s0_d   = in_s0_q;
    in_s1_d   = in_s1_q;
    out_s0_d  = out_s0_q;
    out_s1_d  = out_s1_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    tag_idx_d = tag_idx_q;
    rnd_err_d = rnd_err_q;
    alive_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          in_s0_d = state_in_s0;
          in_s1_d = state_in_s1;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        idx_d   = '0;
      end
      S_RUN: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(NIBBLES - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!any_tag) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      tag_d[0]     = issue;
      tag_idx_d[0] = idx_q;
      for (int k = 1; k < TW; k++) begin
        tag_d[k]     = tag_q[k-1];
        tag_idx_d[k] = tag_idx_q[k-1];
      end
    end
    if (state_q == S_LOAD) tag_d = '0;

    for (int i = 0; i < NIBBLES; i++) begin
      if (wr_en && (wr_idx == IW'(i))) begin
        out_s0_d[4*i +: 4] = sbox.sbox_y_s0;
        out_s1_d[4*i +: 4] = sbox.sbox_y_s1;
      end
    end

`ifndef SKINNY_SCHED_CLK_GATE_EN
    if (any_tag && !fresh_valid) rnd_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      in_s0_q   <= '0;
      in_s1_q   <= '0;
      out_s0_q  <= '0;
      out_s1_q  <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      tag_idx_q <= '{default: '0};
      rnd_err_q <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_s0_q   <= in_s0_d;
      in_s1_q   <= in_s1_d;
      out_s0_q  <= out_s0_d;
      out_s1_q  <= out_s1_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      tag_idx_q <= tag_idx_d;
      rnd_err_q <= rnd_err_d;
      alive_q   <= alive_d;
    end
  end

  assign fresh_ready     = fresh_valid && (issue || any_tag);
  assign sbox.sbox_fresh = fresh_ready ? fresh_in : '0;
  assign sbox.sbox_x_s0  = x_s0;
  assign sbox.sbox_x_s1  = x_s1;
  assign sbox.sbox_en    = advance;
  assign busy            = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign state_out_s0    = out_s0_q;
  assign state_out_s1    = out_s1_q;
  assign rnd_err         = rnd_err_q;
endmodule

// File: tb/tb_skinny_sbox_layer_sched_d1.sv
// tb/tb_skinny_sbox_layer_sched_d1.sv - directed scoreboard bench for the masked S-box layer scheduler
module tb_skinny_sbox_layer_sched_d1;
  localparam int N  = 16;
  localparam int FW = 8;
`ifdef SKINNY_SCHED_CLK_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif
  localparam logic [63:0] T1V = 64'h0123456789ABCDEF;
  localparam logic [63:0] T1R = 64'hC6901A2B385D4E7F;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          fresh_valid = 1'b0;
  logic [63:0]   in_s0 = '0;
  logic [63:0]   in_s1 = '0;
  logic [FW-1:0] fresh_in = '0;
  logic          fresh_ready, busy, done, rnd_err;
  logic [63:0]   out_s0, out_s1;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [63:0]   sbq[$];
  int            dq[$];
  logic [63:0]   mask;

  skinny_sbox_layer_sched_d1_if #(.FRESH_W(FW)) sif ();

  skinny_sbox_layer_sched_d1 #(.NIBBLES(N), .SBOX_LAT(2), .FRESH_W(FW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .state_in_s0  (in_s0),
    .state_in_s1  (in_s1),
    .fresh_in     (fresh_in),
    .fresh_valid  (fresh_valid),
    .fresh_ready  (fresh_ready),
    .sbox         (sif),
    .busy         (busy),
    .done         (done),
    .state_out_s0 (out_s0),
    .state_out_s1 (out_s1),
    .rnd_err      (rnd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sb(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
      4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] sbox_ref(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = sb(v[4*i +: 4]);
    return r;
  endfunction

  // Masked S-box model, one register stage (SBOX_LAT=2 with combinational issue tag)
  logic [3:0] y0_q, y1_q;
  always_ff @(posedge clk) begin
    if (sif.sbox_en) begin
      y0_q <= sb(sif.sbox_x_s0 ^ sif.sbox_x_s1) ^ sif.sbox_x_s1 ^ sif.sbox_fresh[3:0];
      y1_q <= sif.sbox_x_s1 ^ sif.sbox_fresh[3:0];
    end
  end
  assign sif.sbox_y_s0 = y0_q;
  assign sif.sbox_y_s1 = y1_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_run(input string nm, input logic [63:0] plain, input logic [63:0] msk,
                        input logic [63:0] exp_res, input int lo_from, input int lo_n,
                        input int st_a, input int st_b, input int exp_done, input bit chk_out);
    int          issued;
    bit          seen;
    logic [63:0] s0v;
    logic [63:0] exp_v;
    int          exp_c;
    s0v   = plain ^ msk;
    in_s0 = s0v;
    in_s1 = msk;
    sbq.push_back(exp_res);
    dq.push_back(exp_done);
    cyc         = 0;
    start       = 1'b1;
    fresh_valid = 1'b1;
    fresh_in    = FW'($urandom);
    tick;
    issued = 0;
    seen   = 1'b0;
    chk({nm, "_busy_load"}, 64'(busy), 64'd1);
    for (int k = 0; k < 80 && !seen; k++) begin
      start       = (cyc == st_a) || (cyc == st_b);
      fresh_valid = !((cyc >= lo_from) && (cyc < lo_from + lo_n));
      fresh_in    = FW'($urandom);
      #1;
      if ((cyc >= 2) && fresh_valid && (issued < N)) begin
        chk({nm, "_x"}, 64'({sif.sbox_x_s1, sif.sbox_x_s0}),
            64'({msk[4*issued +: 4], s0v[4*issued +: 4]}));
        issued++;
      end
      if ((lo_n > 0) && (cyc == lo_from)) begin
        chk({nm, "_bubble_x"}, 64'({sif.sbox_x_s1, sif.sbox_x_s0}), 64'd0);
        chk({nm, "_starve_en"}, 64'(sif.sbox_en), ((GATE && lo_from > 2) ? 64'd0 : 64'd1));
        chk({nm, "_starve_ready"}, 64'(fresh_ready), 64'd0);
      end
      if (done) begin
        seen  = 1'b1;
        exp_v = sbq.pop_front();
        exp_c = dq.pop_front();
        chk({nm, "_done_cycle"}, 64'(cyc), 64'(exp_c));
        chk({nm, "_busy_done"}, 64'(busy), 64'd0);
        if (chk_out) chk({nm, "_result"}, out_s0 ^ out_s1, exp_v);
      end
      tick;
    end
    chk({nm, "_timeout"}, 64'(seen), 64'd1);
    if (!seen) begin
      void'(sbq.pop_front());
      void'(dq.pop_front());
    end
    start       = 1'b0;
    fresh_valid = 1'b1;
    #1;
    chk({nm, "_single_done"}, 64'(done), 64'd0);
    chk({nm, "_idle1"}, 64'(busy), 64'd0);
    tick;
    chk({nm, "_idle2"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pv;
    rst         = 1'b0;
    fresh_valid = 1'b1;
    fresh_in    = 8'hA5;
    #12;
    chk("rst_out_s0", out_s0, 64'd0);
    chk("rst_out_s1", out_s1, 64'd0);
    chk("rst_flags", 64'({busy, done, rnd_err, fresh_ready, sif.sbox_en}), 64'd0);
    chk("rst_sbox_x", 64'({sif.sbox_x_s1, sif.sbox_x_s0, sif.sbox_fresh}), 64'd0);
    rst = 1'b1;
    tick;
    tick;
    chk("en_after_rst", 64'(sif.sbox_en), 64'd1);

    do_run("t1", T1V, 64'd0, T1R, -1, 0, -1, -1, 20, 1'b1);

    mask = {$urandom(), $urandom()};
    do_run("t2", T1V, mask, T1R, -1, 0, -1, -1, 20, 1'b1);
    total++;
    assert (out_s0 !== T1R) else begin bad++; $error("FAIL t2_share0_plain: observed=%h expected!=%h", out_s0, T1R); end
    total++;
    assert (out_s1 !== T1R) else begin bad++; $error("FAIL t2_share1_plain: observed=%h expected!=%h", out_s1, T1R); end

    pv   = {$urandom(), $urandom()};
    mask = {$urandom(), $urandom()};
    do_run("t3", pv, mask, sbox_ref(pv), 2, 3, -1, -1, 23, 1'b1);
    chk("t3_rnd_err", 64'(rnd_err), 64'd0);

    mask = {$urandom(), $urandom()};
    do_run("t5", T1V, mask, T1R, -1, 0, 8, 20, 20, 1'b1);

    pv   = {$urandom(), $urandom()};
    mask = {$urandom(), $urandom()};
    do_run("t4", pv, mask, sbox_ref(pv), 6, 2, -1, -1, 22, GATE);
    chk("t4_rnd_err", 64'(rnd_err), GATE ? 64'd0 : 64'd1);

    mask  = {$urandom(), $urandom()};
    in_s0 = T1V ^ mask;
    in_s1 = mask;
    cyc   = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (cyc < 10) tick;
    rst = 1'b0;
    #1;
    chk("t6_rst_flags", 64'({busy, done, rnd_err, fresh_ready, sif.sbox_en}), 64'd0);
    chk("t6_rst_out", out_s0 | out_s1, 64'd0);
    chk("t6_rst_x", 64'({sif.sbox_x_s1, sif.sbox_x_s0}), 64'd0);
    tick;
    chk("t6_rst_hold", 64'({busy, done, rnd_err}), 64'd0);
    rst = 1'b1;
    tick;
    tick;
    do_run("t6", T1V, mask, T1R, -1, 0, -1, -1, 20, 1'b1);
    chk("t6_rnd_err", 64'(rnd_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
